// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared FSM encoding, Wishbone cycle-type constants and field widths for the RAM arbiter
package wb_arb_pkg;
    localparam int ADR_W   = 32;
    localparam int DAT_W   = 32;
    localparam int SEL_W   = 4;
    localparam int CTI_W   = 3;
    localparam int BTE_W   = 2;
    localparam int STALL_W = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWNED = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [CTI_W-1:0] CTI_CONST   = 3'b001;
    localparam logic [CTI_W-1:0] CTI_INCR    = 3'b010;
    localparam logic [CTI_W-1:0] CTI_EOB     = 3'b111;

    localparam logic [BTE_W-1:0] BTE_LINEAR = 2'b00;
    localparam logic [BTE_W-1:0] BTE_WRAP4  = 2'b01;
    localparam logic [BTE_W-1:0] BTE_WRAP8  = 2'b10;
    localparam logic [BTE_W-1:0] BTE_WRAP16 = 2'b11;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: combinational round-robin picker, first requester after i_last wins
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt
);
    logic [31:0]  w_sh;
    logic [N-1:0] w_rot;
    logic [N-1:0] w_iso;

    // rotate so bit 0 is the master after i_last, isolate lowest set bit, rotate back
    assign w_sh  = 32'(i_last) + 32'd1;
    assign w_rot = N'({i_req, i_req} >> w_sh);
    assign w_iso = w_rot & (~w_rot + N'(1));
    assign o_gnt = N'(({w_iso, w_iso} << w_sh) >> N);
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin Wishbone arbiter giving several masters access to one RAM slave,
// with a stall watchdog that terminates hung transfers with a bus error
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_n_i,
    input  logic [NUM_MASTERS*ADR_W-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*DAT_W-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*SEL_W-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]       wbm_we_i,
    input  logic [NUM_MASTERS-1:0]       wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]       wbm_stb_i,
    input  logic [NUM_MASTERS*CTI_W-1:0] wbm_cti_i,
    input  logic [NUM_MASTERS*BTE_W-1:0] wbm_bte_i,
    output logic [DAT_W-1:0]             wbm_dat_o,
    output logic [NUM_MASTERS-1:0]       wbm_ack_o,
    output logic [NUM_MASTERS-1:0]       wbm_err_o,
    output logic [NUM_MASTERS-1:0]       wbm_rty_o,
    output logic [ADR_W-1:0]             wbs_adr_o,
    output logic [DAT_W-1:0]             wbs_dat_o,
    output logic [SEL_W-1:0]             wbs_sel_o,
    output logic                         wbs_we_o,
    output logic                         wbs_cyc_o,
    output logic                         wbs_stb_o,
    output logic [CTI_W-1:0]             wbs_cti_o,
    output logic [BTE_W-1:0]             wbs_bte_o,
    input  logic [DAT_W-1:0]             wbs_dat_i,
    input  logic                         wbs_ack_i,
    input  logic                         wbs_err_i,
    input  logic                         wbs_rty_i,
    output logic [NUM_MASTERS-1:0]       grant_o
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IW-1:0]          r_owner;
    logic [IW-1:0]          r_last;
    logic [STALL_W-1:0]     r_stall;
    logic [NUM_MASTERS-1:0] w_pick;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_owned;
    logic                   w_err_st;
    logic                   w_term;
    logic                   w_owner_cyc;
    logic                   w_timeout;

    wb_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .i_req  (wbm_cyc_i),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int m = 0; m < NUM_MASTERS; m++)
            if (w_pick[m]) w_pick_idx = IW'(m);
    end

    assign w_owned     = r_state == ST_OWNED;
    assign w_err_st    = r_state == ST_ERR;
    assign w_term      = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign w_owner_cyc = |(wbm_cyc_i & r_grant);
    assign w_timeout   = wbs_stb_o && !w_term && (r_stall == STALL_W'(TIMEOUT - 1));

    assign grant_o   = r_grant;
    assign wbm_dat_o = w_owned ? wbs_dat_i : '0;
    assign wbm_ack_o = (w_owned && wbs_ack_i) ? r_grant : '0;
    assign wbm_rty_o = (w_owned && wbs_rty_i) ? r_grant : '0;
    assign wbm_err_o = (w_err_st || (w_owned && wbs_err_i)) ? r_grant : '0;

    // slave side mirrors the owner only while OWNED; ERR and IDLE drive zeros
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (w_owned && r_grant[m]) begin
                wbs_adr_o = wbm_adr_i[ADR_W*m +: ADR_W];
                wbs_dat_o = wbm_dat_i[DAT_W*m +: DAT_W];
                wbs_sel_o = wbm_sel_i[SEL_W*m +: SEL_W];
                wbs_we_o  = wbm_we_i[m];
                wbs_cyc_o = wbm_cyc_i[m];
                wbs_stb_o = wbm_stb_i[m];
                wbs_cti_o = wbm_cti_i[CTI_W*m +: CTI_W];
                wbs_bte_o = wbm_bte_i[BTE_W*m +: BTE_W];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
            r_stall <= '0;
        end else begin
            r_stall <= (!wbs_stb_o || w_term) ? '0 : sat_inc(r_stall);
            case (r_state)
                ST_IDLE: begin
                    if (|wbm_cyc_i) begin
                        r_state <= ST_OWNED;
                        r_grant <= w_pick;
                        r_owner <= w_pick_idx;
                    end
                end
                ST_OWNED: begin
                    if (!w_owner_cyc) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_last  <= r_owner;
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_last  <= r_owner;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed bench for the three-master RAM arbiter with an 8-cycle stall watchdog
module tb_wb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [95:0] adr = '0;
    logic [95:0] wdat = '0;
    logic [11:0] sel = '0;
    logic [2:0]  we = '0;
    logic [2:0]  cyc = '0;
    logic [2:0]  stb = '0;
    logic [8:0]  cti = '0;
    logic [5:0]  bte = '0;
    logic [31:0] s_dat = '0;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic        s_rty = 1'b0;
    logic [31:0] dat_o;
    logic [2:0]  ack_o;
    logic [2:0]  err_o;
    logic [2:0]  rty_o;
    logic [31:0] wbs_adr;
    logic [31:0] wbs_dat;
    logic [3:0]  wbs_sel;
    logic        wbs_we;
    logic        wbs_cyc;
    logic        wbs_stb;
    logic [2:0]  wbs_cti;
    logic [1:0]  wbs_bte;
    logic [2:0]  grant;
    int          checks = 0;
    int          errors = 0;

    wb_mem_arbiter #(.NUM_MASTERS(3), .TIMEOUT(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbm_adr_i  (adr),
        .wbm_dat_i  (wdat),
        .wbm_sel_i  (sel),
        .wbm_we_i   (we),
        .wbm_cyc_i  (cyc),
        .wbm_stb_i  (stb),
        .wbm_cti_i  (cti),
        .wbm_bte_i  (bte),
        .wbm_dat_o  (dat_o),
        .wbm_ack_o  (ack_o),
        .wbm_err_o  (err_o),
        .wbm_rty_o  (rty_o),
        .wbs_adr_o  (wbs_adr),
        .wbs_dat_o  (wbs_dat),
        .wbs_sel_o  (wbs_sel),
        .wbs_we_o   (wbs_we),
        .wbs_cyc_o  (wbs_cyc),
        .wbs_stb_o  (wbs_stb),
        .wbs_cti_o  (wbs_cti),
        .wbs_bte_o  (wbs_bte),
        .wbs_dat_i  (s_dat),
        .wbs_ack_i  (s_ack),
        .wbs_err_i  (s_err),
        .wbs_rty_i  (s_rty),
        .grant_o    (grant)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int m, input logic [31:0] a, input logic [2:0] c, input logic on);
        adr[32*m +: 32] = a;
        cti[3*m +: 3]   = c;
        cyc[m]          = on;
        stb[m]          = on;
    endtask

    // called in an idle cycle with master m already requesting; ends in the following dead cycle
    task automatic serve(input int m, input logic [31:0] a, input logic [31:0] d);
        tick;
        chk("grant", grant, 1 << m);
        chk("wbs_adr", wbs_adr, a);
        s_ack = 1'b1;
        s_dat = d;
        settle;
        chk("ack_owner", ack_o, 1 << m);
        chk("rdata", dat_o, d);
        tick;
        req(m, a, 3'b000, 1'b0);
        s_ack = 1'b0;
        settle;
        chk("cyc_drop", wbs_cyc, 0);
        chk("grant_hold", grant, 1 << m);
        tick;
        chk("dead_cycle", grant, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_cyc", wbs_cyc, 0);
        chk("rst_stb", wbs_stb, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_err", err_o, 0);
        rst_n = 1'b1;
        tick;

        req(0, 32'h100, 3'b000, 1'b1);
        settle;
        chk("latency_grant", grant, 0);
        chk("latency_cyc", wbs_cyc, 0);
        serve(0, 32'h100, 32'hDEADBEEF);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick;
        req(0, 32'h10, 3'b000, 1'b1);
        req(1, 32'h20, 3'b000, 1'b1);
        req(2, 32'h30, 3'b000, 1'b1);
        settle;
        serve(0, 32'h10, 32'h11111111);
        serve(1, 32'h20, 32'h22222222);
        serve(2, 32'h30, 32'h33333333);

        req(1, 32'h2000, 3'b010, 1'b1);
        settle;
        tick;
        chk("burst_grant", grant, 3'b010);
        req(2, 32'h3000, 3'b000, 1'b1);
        for (int b = 0; b < 4; b++) begin
            req(1, 32'h2000 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010, 1'b1);
            s_ack = 1'b1;
            settle;
            chk("burst_adr", wbs_adr, 32'h2000 + 32'(4 * b));
            chk("burst_cti", wbs_cti, (b == 3) ? 3'b111 : 3'b010);
            chk("burst_ack", ack_o, 3'b010);
            tick;
        end
        req(1, 32'h0, 3'b000, 1'b0);
        s_ack = 1'b0;
        settle;
        chk("burst_no_preempt", grant, 3'b010);
        chk("burst_ack_done", ack_o, 0);
        tick;
        chk("burst_dead", grant, 0);
        serve(2, 32'h3000, 32'h44444444);

        req(0, 32'h400, 3'b000, 1'b1);
        settle;
        tick;
        for (int k = 0; k < 8; k++) begin
            chk("to_no_err", err_o, 0);
            chk("to_cyc", wbs_cyc, 1);
            tick;
        end
        chk("to_err", err_o, 3'b001);
        chk("to_err_cyc", wbs_cyc, 0);
        chk("to_err_stb", wbs_stb, 0);
        tick;
        chk("to_err_pulse", err_o, 0);
        chk("to_idle", grant, 0);
        req(0, 32'h0, 3'b000, 1'b0);
        tick;

        req(1, 32'h500, 3'b000, 1'b1);
        settle;
        tick;
        chk("late_grant", grant, 3'b010);
        for (int k = 0; k < 7; k++) begin
            chk("late_no_err", err_o, 0);
            tick;
        end
        s_ack = 1'b1;
        settle;
        chk("late_ack", ack_o, 3'b010);
        chk("late_ack_err", err_o, 0);
        tick;
        req(1, 32'h0, 3'b000, 1'b0);
        s_ack = 1'b0;
        settle;
        chk("late_after_err", err_o, 0);
        chk("late_hold", grant, 3'b010);
        tick;
        chk("late_idle", grant, 0);
        chk("late_idle_err", err_o, 0);

        req(1, 32'h2000, 3'b010, 1'b1);
        settle;
        tick;
        chk("mid_grant", grant, 3'b010);
        s_ack = 1'b1;
        settle;
        tick;
        req(1, 32'h2004, 3'b010, 1'b1);
        settle;
        chk("mid_ack", ack_o, 3'b010);
        rst_n = 1'b0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_cyc", wbs_cyc, 0);
        chk("arst_stb", wbs_stb, 0);
        chk("arst_adr", wbs_adr, 0);
        chk("arst_ack", ack_o, 0);
        chk("arst_err", err_o, 0);
        chk("arst_dat", dat_o, 0);
        req(1, 32'h0, 3'b000, 1'b0);
        s_ack = 1'b0;
        tick;
        rst_n = 1'b1;
        req(1, 32'h60, 3'b000, 1'b1);
        req(0, 32'h40, 3'b000, 1'b1);
        settle;
        serve(0, 32'h40, 32'h12345678);
        tick;
        chk("post_rst_next", grant, 3'b010);
        req(1, 32'h0, 3'b000, 1'b0);
        tick;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
